// File: rtl/dec_syndrome_checker.sv
// RS syndrome checker: Horner-evaluates RS_PAR_LEN syndromes over a multi-symbol beat stream; DEC_ERR_COUNT_EN adds err_count.
// Latency: syn_valid/syn_data/syn_err are registered 1 clk after the beat carrying the last codeword symbol.
// Backpressure: none; every in_valid beat is consumed.
module dec_syndrome_checker #(
    parameter int                 EGF_ORDER    = 8,
    parameter logic [EGF_ORDER:0] EGF_PRIM_POL = 9'h11D,
    parameter int                 ENC_SYM_NUM  = 8,
    parameter int                 RS_COD_LEN   = 255,
    parameter int                 RS_PAR_LEN   = 16,
    parameter int                 RS_FCR       = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic                              in_sof,
    input  logic [ENC_SYM_NUM*EGF_ORDER-1:0]  data_in,
    output logic                              syn_valid,
    output logic [RS_PAR_LEN*EGF_ORDER-1:0]   syn_data,
    output logic                              syn_err,
    output logic                              syn_abort
`ifdef DEC_ERR_COUNT_EN
    ,
    output logic [15:0]                       err_count
`endif
);

    localparam int M     = EGF_ORDER;
    localparam int N     = ENC_SYM_NUM;
    localparam int ORD   = (1 << EGF_ORDER) - 1;
    localparam int CNT_W = $clog2(RS_COD_LEN);

    typedef logic [M-1:0] sym_t;

    function automatic sym_t xtime(input sym_t a);
        return a[M-1] ? ((a << 1) ^ EGF_PRIM_POL[M-1:0]) : (a << 1);
    endfunction

    // Constant multiply by alpha^k: k is elaboration-time, so this unrolls to a fixed XOR network.
    function automatic sym_t mul_apow(input sym_t a, input int k);
        sym_t r;
        r = a;
        for (int t = 0; t < k; t++) r = xtime(r);
        return r;
    endfunction

    logic [RS_PAR_LEN*M-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    syn_valid_q, syn_valid_d;
    logic                    syn_abort_q, syn_abort_d;
    logic                    syn_err_q;
    logic [RS_PAR_LEN*M-1:0] syn_data_q;

    logic                    sof_beat;
    logic [CNT_W-1:0]        cnt_eff;
    logic [CNT_W:0]          rem;
    logic                    complete;
    logic [RS_PAR_LEN*M-1:0] fin_syn;
    sym_t                    acc_w, fin_w;

    always_comb begin
        sof_beat    = in_valid && in_sof;
        cnt_eff     = sof_beat ? '0 : cnt_q;
        rem         = (CNT_W+1)'(RS_COD_LEN) - {1'b0, cnt_eff};
        complete    = in_valid && (rem <= (CNT_W+1)'(N));
        syn_abort_d = sof_beat && (cnt_q != '0);
        syn_valid_d = complete;

        if (!in_valid)
            cnt_d = cnt_q;
        else if (complete)
            cnt_d = CNT_W'((CNT_W+1)'(N) - rem);
        else
            cnt_d = cnt_eff + CNT_W'(N);
    end

    // Symbols run earliest-first from index N-1 down to 0; at position rem the finished word is
    // captured and the accumulator restarts from zero for the next codeword.
    always_comb begin
        acc_d   = acc_q;
        fin_syn = '0;
        acc_w   = '0;
        fin_w   = '0;
        for (int j = 0; j < RS_PAR_LEN; j++) begin
            acc_w = sof_beat ? '0 : acc_q[j*M +: M];
            fin_w = '0;
            for (int p = 0; p < N; p++) begin
                if (complete && ((CNT_W+1)'(p) == rem))
                    acc_w = '0;
                acc_w = mul_apow(acc_w, (RS_FCR + j) % ORD) ^ data_in[(N-p)*M-1 -: M];
                if (complete && ((CNT_W+1)'(p + 1) == rem))
                    fin_w = acc_w;
            end
            if (in_valid)
                acc_d[j*M +: M] = acc_w;
            fin_syn[j*M +: M] = fin_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            syn_valid_q <= 1'b0;
            syn_abort_q <= 1'b0;
            syn_err_q   <= 1'b0;
            syn_data_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            syn_valid_q <= syn_valid_d;
            syn_abort_q <= syn_abort_d;
            if (complete) begin
                syn_data_q <= fin_syn;
                syn_err_q  <= |fin_syn;
            end
        end
    end

    assign syn_valid = syn_valid_q;
    assign syn_abort = syn_abort_q;
    assign syn_err   = syn_err_q;
    assign syn_data  = syn_data_q;

`ifdef DEC_ERR_COUNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (complete && (|fin_syn) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else
            err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dec_syndrome_checker.sv
// Bench for dec_syndrome_checker: randomized codeword streams against a direct polynomial-evaluation model.
module tb_dec_syndrome_checker;

    localparam int M   = 8;
    localparam int N   = 8;
    localparam int L   = 255;
    localparam int P   = 16;
    localparam int FCR = 0;
    localparam logic [8:0] POLY = 9'h11D;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_sof = 1'b0;
    logic [N*M-1:0] data_in = '0;
    logic           syn_valid;
    logic [P*M-1:0] syn_data;
    logic           syn_err;
    logic           syn_abort;
`ifdef DEC_ERR_COUNT_EN
    logic [15:0]    err_count;
`endif

    dec_syndrome_checker #(
        .EGF_ORDER(M), .EGF_PRIM_POL(POLY), .ENC_SYM_NUM(N),
        .RS_COD_LEN(L), .RS_PAR_LEN(P), .RS_FCR(FCR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .data_in(data_in), .syn_valid(syn_valid), .syn_data(syn_data),
        .syn_err(syn_err), .syn_abort(syn_abort)
`ifdef DEC_ERR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int n_valid_obs = 0;
    int n_abort_obs = 0;
    bit clean_mode = 1'b0;

    logic [7:0]     exp_tab [255];
    logic [7:0]     gen [P+1];
    logic [7:0]     mq [$];
    logic [7:0]     sq [$];
    logic           exp_valid = 1'b0, exp_abort = 1'b0, exp_err = 1'b0;
    logic [P*M-1:0] exp_data = '0;
    int             exp_ecnt = 0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ POLY[7:0]) : (a << 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a, r;
        a = a_in;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ a;
            a = xt(a);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [P*M-1:0] obs, input logic [P*M-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("syn_valid", syn_valid, exp_valid);
        chk("syn_abort", syn_abort, exp_abort);
        chk("syn_data", syn_data, exp_data);
        chk("syn_err", syn_err, exp_err);
`ifdef DEC_ERR_COUNT_EN
        chk("err_count", err_count, 16'(exp_ecnt));
`endif
        if (clean_mode && exp_valid) chk("clean_err", syn_err, 1'b0);
        if (syn_valid === 1'b1) n_valid_obs++;
        if (syn_abort === 1'b1) n_abort_obs++;
    endtask

    // Syndrome j = c(alpha^(FCR+j)); mq[0] is the coefficient of x^(L-1).
    task automatic model_complete();
        logic [7:0] s;
        for (int j = 0; j < P; j++) begin
            s = 8'h00;
            for (int i = 0; i < L; i++)
                s = s ^ gf_mul(mq[i], exp_tab[((FCR + j) * (L - 1 - i)) % 255]);
            exp_data[j*M +: M] = s;
        end
        exp_valid = 1'b1;
        exp_err   = |exp_data;
        if (exp_err && exp_ecnt < 65535) exp_ecnt++;
        mq.delete();
    endtask

    task automatic model_beat(input logic sof, input logic [N*M-1:0] d);
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (sof) begin
            if (mq.size() != 0) exp_abort = 1'b1;
            mq.delete();
        end
        for (int p = 0; p < N; p++) begin
            mq.push_back(d[(N-p)*M-1 -: M]);
            if (mq.size() == L) model_complete();
        end
    endtask

    task automatic drive(input logic sof, input logic [N*M-1:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        data_in  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        model_beat(sof, d);
        check_outputs();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        exp_err   = 1'b0;
        exp_data  = '0;
        exp_ecnt  = 0;
        check_outputs();
    endtask

    task automatic send_stream(input bit first_sof, input int gap_pct, input int sof_pct);
        logic [N*M-1:0] d;
        bit first;
        first = 1'b1;
        while (sq.size() > 0) begin
            for (int p = 0; p < N; p++)
                d[(N-p)*M-1 -: M] = (sq.size() > 0) ? sq.pop_front() : 8'($urandom);
            drive((first && first_sof) || (!first && $urandom_range(99) < sof_pct), d);
            first = 1'b0;
            if ($urandom_range(99) < gap_pct) idle();
        end
    endtask

    // Systematic encode: c(x) = m(x)x^P + (m(x)x^P mod g(x)); optional corruption of random symbols.
    task automatic push_codeword(input int n_corrupt);
        logic [7:0] r [P];
        logic [7:0] w [$];
        logic [7:0] m, fb;
        int pos;
        for (int k = 0; k < P; k++) r[k] = 8'h00;
        for (int i = 0; i < L - P; i++) begin
            m = 8'($urandom);
            w.push_back(m);
            fb = m ^ r[P-1];
            for (int k = P - 1; k > 0; k--) r[k] = r[k-1] ^ gf_mul(fb, gen[k]);
            r[0] = gf_mul(fb, gen[0]);
        end
        for (int k = P - 1; k >= 0; k--) w.push_back(r[k]);
        for (int e = 0; e < n_corrupt; e++) begin
            pos = $urandom_range(L - 1);
            w[pos] = w[pos] ^ 8'($urandom_range(255, 1));
        end
        foreach (w[i]) sq.push_back(w[i]);
    endtask

    initial begin
        int base;
        exp_tab[0] = 8'h01;
        for (int i = 1; i < 255; i++) exp_tab[i] = xt(exp_tab[i-1]);
        for (int k = 0; k <= P; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int i = 0; i < P; i++) begin
            for (int k = P; k > 0; k--) gen[k] = gen[k-1] ^ gf_mul(gen[k], exp_tab[(FCR + i) % 255]);
            gen[0] = gf_mul(gen[0], exp_tab[(FCR + i) % 255]);
        end

        do_reset();

        // All-zero aligned stream: completion lands inside beat 32.
        for (int i = 0; i < 256; i++) sq.push_back(8'h00);
        base = n_valid_obs;
        send_stream(1'b1, 0, 0);
        chk("zero_word_pulses", 32'(n_valid_obs - base), 32'd1);
        chk("zero_word_err", syn_err, 1'b0);

        // Eight clean encoded words back-to-back with idle gaps.
        do_reset();
        clean_mode = 1'b1;
        for (int c = 0; c < 8; c++) push_codeword(0);
        base = n_valid_obs;
        send_stream(1'b1, 20, 0);
        chk("clean_pulses", 32'(n_valid_obs - base), 32'd8);
        clean_mode = 1'b0;

        // Single error in the first (highest-degree) symbol.
        sq.push_back(8'h01);
        for (int i = 0; i < 255; i++) sq.push_back(8'h00);
        send_stream(1'b1, 0, 0);
        chk("single_s0", syn_data[7:0], 8'h01);
        chk("single_s1", syn_data[15:8], 8'h8E);
        chk("single_err", syn_err, 1'b1);

        // Abort after 10 beats, then a clean word.
        for (int i = 0; i < 10 * N; i++) sq.push_back(8'($urandom));
        send_stream(1'b1, 0, 0);
        base = n_abort_obs;
        push_codeword(0);
        send_stream(1'b1, 0, 0);
        chk("abort_pulses", 32'(n_abort_obs - base), 32'd1);
        chk("after_abort_err", syn_err, 1'b0);

        // Reset mid-codeword, then a clean word with in_sof: no abort.
        for (int i = 0; i < 5 * N; i++) sq.push_back(8'($urandom));
        send_stream(1'b1, 0, 0);
        do_reset();
        base = n_abort_obs;
        push_codeword(0);
        send_stream(1'b1, 10, 0);
        chk("reset_no_abort", 32'(n_abort_obs - base), 32'd0);
        chk("reset_word_err", syn_err, 1'b0);

        // Random mix of clean and corrupted words with occasional stray in_sof.
        for (int c = 0; c < 6; c++) push_codeword(($urandom_range(1) == 1) ? int'($urandom_range(3, 1)) : 0);
        send_stream(1'b1, 15, 2);

`ifdef DEC_ERR_COUNT_EN
        do_reset();
        push_codeword(2);
        push_codeword(0);
        push_codeword(1);
        push_codeword(0);
        push_codeword(3);
        send_stream(1'b1, 10, 0);
        chk("err_count_three", err_count, 16'd3);
`endif

        repeat (3) idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dec_syndrome_checker.md
Name: dec_syndrome_checker

Overview:
- Receive-side counterpart of the multi-symbol RS encoder.
- Accepts ENC_SYM_NUM GF(2^EGF_ORDER) symbols per beat from a contiguous stream of RS_COD_LEN-symbol codewords. Codeword boundaries may fall mid-beat.
- Computes the RS_PAR_LEN syndromes of each codeword by per-symbol Horner evaluation, splitting each beat at the boundary.
- Reports the syndromes and an error flag per codeword; feeds the future key-equation/Chien stages.

Parameters:
- EGF_ORDER, 8, symbol width in bits (GF(2^m) order)
- EGF_PRIM_POL, 9'h11D, field primitive polynomial, EGF_ORDER+1 bits
- ENC_SYM_NUM, 8, symbols per beat
- RS_COD_LEN, 255, codeword length in symbols; must satisfy ENC_SYM_NUM < RS_COD_LEN <= 2^EGF_ORDER-1
- RS_PAR_LEN, 16, parity symbols = number of syndromes
- RS_FCR, 0, first consecutive root: syndrome j evaluates at alpha^(RS_FCR+j)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  beat qualifier
- in_sof  in  1  with in_valid: symbol ENC_SYM_NUM-1 of this beat is the first symbol of a codeword
- data_in  in  ENC_SYM_NUM*EGF_ORDER  symbol i = data_in[(i+1)*EGF_ORDER-1 -: EGF_ORDER]; highest i is earliest in time
- syn_valid  out  1  one-cycle pulse: syndromes of a completed codeword
- syn_data  out  RS_PAR_LEN*EGF_ORDER  syndrome j at [(j+1)*EGF_ORDER-1 -: EGF_ORDER]
- syn_err  out  1  OR of all syndromes != 0; qualified by syn_valid
- syn_abort  out  1  pulse: a partial codeword was discarded by in_sof

Behaviour:
- Reset:
  - Applies when rst_n=0 at posedge clk.
  - syn_valid, syn_err and syn_abort go to 0; syn_data goes to 0.
  - Internal accumulators and symbol counter cnt go to 0; the next beat is treated as a codeword start.
- Reset mid-codeword discards the partial accumulation with no abort pulse.
- Symbol order:
  - Earliest symbol is the highest-degree coefficient c_(n-1).
  - Horner step per symbol s, per syndrome j: A_j <= A_j*alpha^(RS_FCR+j) XOR s.
  - Multipliers are constant GF multipliers reduced by EGF_PRIM_POL. No general multipliers.
- Beat processing (in_valid=1):
  - rem = RS_COD_LEN - cnt.
  - If rem > ENC_SYM_NUM: all symbols are folded into A; cnt += ENC_SYM_NUM.
  - If rem <= ENC_SYM_NUM:
    - The first rem symbols complete the codeword; the result is registered to syn_data.
    - syn_valid=1 next cycle.
    - The remaining ENC_SYM_NUM-rem symbols seed a fresh accumulation starting from 0.
    - cnt = ENC_SYM_NUM-rem.
    - rem == ENC_SYM_NUM gives a clean aligned boundary with cnt=0.
- At most one codeword completes per beat, guaranteed by RS_COD_LEN > ENC_SYM_NUM.
- in_valid=0: no state change; outputs hold except the pulses, which drop to 0.
- Latency: syn_valid is asserted exactly 1 clk after the beat carrying the last symbol.
- syn_data and syn_err hold their value until the next completion.
- in_sof:
  - Forces cnt to 0 and A to 0 before processing the beat.
  - If cnt != 0 at that time: syn_abort=1 for one cycle and no syn_valid for the discarded word.
  - in_sof with cnt == 0: no abort.
  - If the same beat would otherwise have completed a codeword (rem <= ENC_SYM_NUM and cnt != 0), in_sof wins: abort and no completion.
- cnt width is $clog2(RS_COD_LEN). Arithmetic never wraps past RS_COD_LEN-1.
- There is no backpressure; the block accepts every valid beat.

Optional Feature:
- Macro DEC_ERR_COUNT_EN.
- When defined:
  - Adds output err_count, 16 bits.
  - It is a saturating count of syn_valid pulses with syn_err=1.
  - Reset to 0; it sticks at 16'hFFFF.
  - Updates in the same cycle syn_valid is asserted.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults; 32 aligned beats of all-zero data with in_sof on the first -> syn_valid after beats 32 (RS_COD_LEN=255 spans beat 32, cnt then 1), syn_data=0, syn_err=0.
- Defaults; encoder-produced codewords streamed back-to-back for 8 codewords (boundary at offsets 7,6,...,0) -> 8 pulses, each syn_err=0; syn_valid 1 clk after each boundary beat.
- Single error: zero codeword with first symbol = 8'h01 -> S_0=8'h01, S_j=alpha^(-j) (S_1=8'h8E), syn_err=1.
- in_sof at beat 10 of a codeword -> syn_abort pulse; no syn_valid for that word; next word's syndromes are correct.
- rst_n low for 1 cycle mid-codeword, then a clean codeword with in_sof -> no abort; one correct syn_valid.
- DEC_ERR_COUNT_EN: 3 corrupted words plus 2 clean ones -> err_count=3; preload near saturation -> stays at 16'hFFFF.
